// File: rtl/inst_buffer.sv
// Circular instruction FIFO between fetch and dispatch.
// The head entry is read with zero latency, and ib_full is raised one slot early.
module inst_buffer #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [31:0]              in_inst,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_npc,
    output logic                     ib_full,
    input  logic                     dp_ready,
    output logic                     dp_valid,
    output logic [31:0]              dp_inst,
    output logic [XLEN-1:0]          dp_pc,
    output logic [XLEN-1:0]          dp_npc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]     r_inst [DEPTH];
    logic [XLEN-1:0] r_pc   [DEPTH];
    logic [XLEN-1:0] r_npc  [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic            r_overflow;

    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_full = (r_count == CW'(DEPTH));
    assign w_pop  = dp_ready && dp_valid && !flush;
    assign w_push = in_valid && !flush && (!w_full || w_pop);
    assign w_drop = in_valid && !flush && w_full && !w_pop;

    // Storage is deliberately left out of reset; only the pointers decide validity.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_inst[r_tail] <= in_inst;
            r_pc[r_tail]   <= in_pc;
            r_npc[r_tail]  <= in_npc;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign dp_valid = (r_count != '0);
    assign dp_inst  = dp_valid ? r_inst[r_head] : '0;
    assign dp_pc    = dp_valid ? r_pc[r_head]   : '0;
    assign dp_npc   = dp_valid ? r_npc[r_head]  : '0;
    assign ib_full  = (r_count >= CW'(DEPTH - 1));
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer (DEPTH=8, XLEN=32).
module tb_inst_buffer;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        inValid;
    logic [31:0] inInst;
    logic [31:0] inPc;
    logic [31:0] inNpc;
    logic        ibFull;
    logic        dpReady;
    logic        dpValid;
    logic [31:0] dpInst;
    logic [31:0] dpPc;
    logic [31:0] dpNpc;
    logic [3:0]  count;
    logic        overflow;

    int checks;
    int failures;

    inst_buffer #(.DEPTH(8), .XLEN(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .in_valid (inValid),
        .in_inst  (inInst),
        .in_pc    (inPc),
        .in_npc   (inNpc),
        .ib_full  (ibFull),
        .dp_ready (dpReady),
        .dp_valid (dpValid),
        .dp_inst  (dpInst),
        .dp_pc    (dpPc),
        .dp_npc   (dpNpc),
        .count    (count),
        .overflow (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drives one fetch packet; instruction and NPC are derived from the PC.
    task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic ready, input logic fl);
        inValid = valid;
        inPc    = pc;
        inNpc   = pc + 32'd4;
        inInst  = 32'hA000_0000 | pc;
        dpReady = ready;
        flush   = fl;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) tick();
        checkOutput("rst_dp_valid", {63'd0, dpValid}, 64'd0);
        checkOutput("rst_count", {60'd0, count}, 64'd0);
        reset = 1'b1;
        tick();
        checkOutput("idle_dp_valid", {63'd0, dpValid}, 64'd0);
        checkOutput("idle_count", {60'd0, count}, 64'd0);
        checkOutput("idle_ib_full", {63'd0, ibFull}, 64'd0);
        checkOutput("idle_dp_inst", {32'd0, dpInst}, 64'd0);
        checkOutput("idle_overflow", {63'd0, overflow}, 64'd0);

        $display("[TB] fill without pop");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'(i * 4), 1'b0, 1'b0);
            tick();
            if (i == 5) checkOutput("fill6_ib_full", {63'd0, ibFull}, 64'd0);
            if (i == 6) begin
                checkOutput("fill7_count", {60'd0, count}, 64'd7);
                checkOutput("fill7_ib_full", {63'd0, ibFull}, 64'd1);
            end
        end
        checkOutput("full_count", {60'd0, count}, 64'd8);
        checkOutput("full_overflow", {63'd0, overflow}, 64'd0);
        checkOutput("full_head_pc", {32'd0, dpPc}, 64'h0);
        checkOutput("full_head_inst", {32'd0, dpInst}, 64'hA000_0000);
        checkOutput("full_head_npc", {32'd0, dpNpc}, 64'h4);

        $display("[TB] overflow then drain");
        applyStimulus(1'b1, 32'h20, 1'b0, 1'b0);
        tick();
        checkOutput("ovf_count", {60'd0, count}, 64'd8);
        checkOutput("ovf_flag", {63'd0, overflow}, 64'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checkOutput("drain_pc", {32'd0, dpPc}, 64'(i * 4));
            tick();
        end
        checkOutput("drained_count", {60'd0, count}, 64'd0);
        checkOutput("drained_dp_valid", {63'd0, dpValid}, 64'd0);
        checkOutput("drained_dp_pc", {32'd0, dpPc}, 64'd0);
        checkOutput("ovf_sticky", {63'd0, overflow}, 64'd1);

        $display("[TB] push and pop at full across wrap");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'h200 + 32'(i * 4), 1'b0, 1'b0);
            tick();
        end
        checkOutput("refill_count", {60'd0, count}, 64'd8);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 32'h220 + 32'(k * 4), 1'b1, 1'b0);
            checkOutput("pp_head_pc", {32'd0, dpPc}, 64'(32'h200 + 32'(k * 4)));
            tick();
            checkOutput("pp_count", {60'd0, count}, 64'd8);
        end
        checkOutput("pp_final_pc", {32'd0, dpPc}, 64'h250);
        checkOutput("pp_final_inst", {32'd0, dpInst}, 64'hA000_0250);

        $display("[TB] flush mid-stream");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (3) tick();
        checkOutput("preflush_count", {60'd0, count}, 64'd5);
        applyStimulus(1'b1, 32'h999, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("flush_count", {60'd0, count}, 64'd0);
        checkOutput("flush_dp_valid", {63'd0, dpValid}, 64'd0);
        checkOutput("flush_ib_full", {63'd0, ibFull}, 64'd0);
        checkOutput("flush_ovf_kept", {63'd0, overflow}, 64'd1);
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0);
        tick();
        checkOutput("postflush_valid", {63'd0, dpValid}, 64'd1);
        checkOutput("postflush_pc", {32'd0, dpPc}, 64'h100);
        checkOutput("postflush_count", {60'd0, count}, 64'd1);

        $display("[TB] async reset mid-operation");
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("prereset_count", {60'd0, count}, 64'd6);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_count", {60'd0, count}, 64'd0);
        checkOutput("async_dp_valid", {63'd0, dpValid}, 64'd0);
        checkOutput("async_dp_pc", {32'd0, dpPc}, 64'd0);
        checkOutput("async_overflow", {63'd0, overflow}, 64'd0);
        #1;
        reset = 1'b1;
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b0);
        tick();
        checkOutput("resume_count", {60'd0, count}, 64'd1);
        checkOutput("resume_pc", {32'd0, dpPc}, 64'h300);
        applyStimulus(1'b1, 32'h304, 1'b1, 1'b0);
        tick();
        checkOutput("one_pp_count", {60'd0, count}, 64'd1);
        checkOutput("one_pp_pc", {32'd0, dpPc}, 64'h304);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("end_count", {60'd0, count}, 64'd0);
        checkOutput("end_dp_valid", {63'd0, dpValid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
